// File: rtl/cu_em_stage.sv
// Execute-stage branch resolution and the Execute->Memory pipeline register.
// Latency: PCSrcE is combinational (0 cycles); E values reach the M outputs 1 cycle later.
// Backpressure: StallM holds the M register (E inputs dropped), FlushM loads a bubble.
module cu_em_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidE,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic [2:0]            Funct3E,
  input  logic                  ZeroE,
  input  logic                  LtE,
  input  logic                  LtuE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic [REG_AW-1:0]     RdE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic                  StallM,
  input  logic                  FlushM,
  output logic                  PCSrcE,
  output logic                  ValidM,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  MemWriteM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [REG_AW-1:0]     RdM,
  output logic [DATA_WIDTH-1:0] PCPlus4M
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } m_bundle_t;

  m_bundle_t m_d;
  m_bundle_t m_q;
  logic      branch_cond;

  // Evaluate the branch condition from the ALU flags and drive the fetch redirect
  always_comb begin
    branch_cond = 1'b0;
    case (Funct3E)
      3'b000:  branch_cond = ZeroE;   // beq
      3'b001:  branch_cond = ~ZeroE;  // bne
      3'b100:  branch_cond = LtE;     // blt
      3'b101:  branch_cond = ~LtE;    // bge
      3'b110:  branch_cond = LtuE;    // bltu
      3'b111:  branch_cond = ~LtuE;   // bgeu
      default: branch_cond = 1'b0;    // 010/011 are not branches
    endcase
    PCSrcE = ValidE & (JumpE | (BranchE & branch_cond));
  end

  // Next M bundle: a flush bubble beats a stall, which beats a normal load
  always_comb begin
    m_d = m_q;
    if (FlushM) begin
      m_d = '0;
    end else if (!StallM) begin
      m_d.valid      = ValidE;
      // Writes to x0 are squashed here so later stages never need to check Rd
      m_d.reg_write  = ValidE & RegWriteE & (RdE != '0);
      m_d.result_src = ResultSrcE;
      m_d.mem_write  = ValidE & MemWriteE;
      m_d.alu_result = ALUResultE;
      m_d.write_data = WriteDataE;
      m_d.rd         = RdE;
      m_d.pc_plus4   = PCPlus4E;
    end
  end

  // M pipeline register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
    end else begin
      m_q <= m_d;
    end
  end

  assign ValidM     = m_q.valid;
  assign RegWriteM  = m_q.reg_write;
  assign ResultSrcM = m_q.result_src;
  assign MemWriteM  = m_q.mem_write;
  assign ALUResultM = m_q.alu_result;
  assign WriteDataM = m_q.write_data;
  assign RdM        = m_q.rd;
  assign PCPlus4M   = m_q.pc_plus4;

endmodule
